// File: rtl/rbm_pkg.sv
// Shared defaults, FSM state encoding and address-width helper
// for the RBM inference sequencer.
package rbm_pkg;

    localparam int N_VIS_DEF    = 784;
    localparam int N_HID_DEF    = 441;
    localparam int N_CLS_DEF    = 10;
    localparam int W_BITS_DEF   = 12;
    localparam int CNT_BITS_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HID,
        S_HID_CAP,
        S_CLS,
        S_CLS_CAP,
        S_ITER_END,
        S_DONE
    } rbm_state_t;

    // Never return a zero-width address for single-entry memories
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VIS_AW_DEF = addr_w(N_VIS_DEF);
    localparam int HID_AW_DEF = addr_w(N_HID_DEF + 1);
    localparam int CLS_AW_DEF = addr_w(N_CLS_DEF);

endpackage

// File: rtl/rbm_argmax.sv
// N-way maximum search over packed spike counters.
// Strict greater-than keeps the lowest index on ties.
module rbm_argmax
    import rbm_pkg::*;
#(
    parameter int N_CLS    = N_CLS_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF,
    parameter int IDX_W    = addr_w(N_CLS)
) (
    input  logic [N_CLS*CNT_BITS-1:0] i_counts,
    output logic [IDX_W-1:0]          o_idx
);

    logic [CNT_BITS-1:0] w_best;

    always_comb begin
        o_idx  = '0;
        w_best = i_counts[CNT_BITS-1:0];
        for (int i = 1; i < N_CLS; i++) begin
            if (i_counts[i*CNT_BITS +: CNT_BITS] > w_best) begin
                w_best = i_counts[i*CNT_BITS +: CNT_BITS];
                o_idx  = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rbm_sequencer.sv
// Drives hidden and classifier neuron passes through a shared
// neuron core and accumulates classifier spikes per iteration.
module rbm_sequencer
    import rbm_pkg::*;
#(
    parameter int N_VIS    = N_VIS_DEF,
    parameter int N_HID    = N_HID_DEF,
    parameter int N_CLS    = N_CLS_DEF,
    parameter int W_BITS   = W_BITS_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF,
    localparam int VIS_AW  = addr_w(N_VIS),
    localparam int HID_AW  = addr_w(N_HID + 1),
    localparam int CLS_AW  = addr_w(N_CLS)
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [CNT_BITS-1:0]       i_iter_num,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [VIS_AW-1:0]         o_vis_addr,
    input  logic                      i_vis_bit,
    output logic [HID_AW-1:0]         o_hid_addr,
    output logic [CLS_AW-1:0]         o_cls_addr,
    input  logic [W_BITS-1:0]         i_h_value,
    input  logic [W_BITS-1:0]         i_c_value,
    input  logic                      i_sw_bit,
    output logic                      o_core_en_hidden,
    output logic                      o_core_en_classi,
    output logic                      o_core_first,
    output logic                      o_core_pixel,
    output logic [W_BITS-1:0]         o_core_value,
    output logic                      o_core_switch,
    input  logic                      i_core_hidden,
    input  logic                      i_core_spike,
    output logic [N_CLS*CNT_BITS-1:0] o_spike_count,
    output logic [CLS_AW-1:0]         o_class_out
);

    localparam int K_W = addr_w(N_VIS + 1);

    rbm_state_t                r_state;
    logic [K_W-1:0]            r_k;
    logic [HID_AW-1:0]         r_hid;
    logic [CLS_AW-1:0]         r_cls;
    logic [CNT_BITS-1:0]       r_iter;
    logic [CNT_BITS-1:0]       r_iter_num;
    logic [N_HID:0]            r_hbuf;
    logic [N_CLS*CNT_BITS-1:0] r_cnt;
    logic [CLS_AW-1:0]         r_class;
    logic                      r_busy;
    logic                      r_done;

    logic [CLS_AW-1:0]         w_argmax;
    logic [CNT_BITS-1:0]       w_cur_cnt;
    logic [CNT_BITS-1:0]       w_iter_nxt;
    logic                      w_vis_bias;
    logic                      w_cls_bias;

    rbm_argmax #(
        .N_CLS    (N_CLS),
        .CNT_BITS (CNT_BITS),
        .IDX_W    (CLS_AW)
    ) u_argmax (
        .i_counts (r_cnt),
        .o_idx    (w_argmax)
    );

    always_comb begin
        w_cur_cnt  = r_cnt[int'(r_cls)*CNT_BITS +: CNT_BITS];
        w_iter_nxt = r_iter + 1'b1;
        w_vis_bias = (r_k == K_W'(N_VIS));
        w_cls_bias = (r_hid == HID_AW'(N_HID));
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_hid      <= '0;
            r_cls      <= '0;
            r_iter     <= '0;
            r_iter_num <= '0;
            r_hbuf     <= '0;
            r_cnt      <= '0;
            r_class    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_k        <= '0;
                        r_hid      <= '0;
                        r_cls      <= '0;
                        r_iter     <= '0;
                        r_iter_num <= i_iter_num;
                        r_hbuf     <= '0;
                        r_cnt      <= '0;
                        r_class    <= '0;
                        if (i_iter_num == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_HID;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_HID: begin
                    if (w_vis_bias) begin
                        r_k     <= '0;
                        r_state <= S_HID_CAP;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_HID_CAP: begin
                    r_hbuf[r_hid] <= i_core_hidden;
                    if (r_hid == HID_AW'(N_HID - 1)) begin
                        r_hid   <= '0;
                        r_state <= S_CLS;
                    end else begin
                        r_hid   <= r_hid + 1'b1;
                        r_state <= S_HID;
                    end
                end
                S_CLS: begin
                    if (w_cls_bias) begin
                        r_state <= S_CLS_CAP;
                    end else begin
                        r_hid <= r_hid + 1'b1;
                    end
                end
                S_CLS_CAP: begin
                    // Counters stick at all-ones rather than wrapping
                    if (i_core_spike && (w_cur_cnt != '1)) begin
                        r_cnt[int'(r_cls)*CNT_BITS +: CNT_BITS] <=
                            w_cur_cnt + 1'b1;
                    end
                    r_hid <= '0;
                    if (r_cls == CLS_AW'(N_CLS - 1)) begin
                        r_cls   <= '0;
                        r_state <= S_ITER_END;
                    end else begin
                        r_cls   <= r_cls + 1'b1;
                        r_state <= S_CLS;
                    end
                end
                S_ITER_END: begin
                    r_iter <= w_iter_nxt;
                    if (w_iter_nxt == r_iter_num) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_class <= w_argmax;
                    end else begin
                        r_state <= S_HID;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_core_en_hidden = (r_state == S_HID) || (r_state == S_HID_CAP);
        o_core_en_classi = (r_state == S_CLS) || (r_state == S_CLS_CAP);
        o_core_switch    = o_core_en_hidden & i_sw_bit;
        o_core_first     = 1'b0;
        o_core_pixel     = 1'b0;
        o_core_value     = '0;
        if (r_state == S_HID) begin
            o_core_first = (r_k == '0);
            o_core_pixel = w_vis_bias ? 1'b1 : i_vis_bit;
            o_core_value = i_h_value;
        end else if (r_state == S_CLS) begin
            o_core_first = (r_hid == '0);
            o_core_pixel = w_cls_bias ? 1'b1 : r_hbuf[r_hid];
            o_core_value = i_c_value;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_vis_addr    = r_k[VIS_AW-1:0];
    assign o_hid_addr    = r_hid;
    assign o_cls_addr    = r_cls;
    assign o_spike_count = r_cnt;
    assign o_class_out   = r_class;

endmodule

// File: tb/tb_rbm_sequencer.sv
// Scoreboard bench: expected per-cycle operand stream is queued
// at start and popped against the DUT each busy cycle.
module tb_rbm_sequencer;

    localparam int NV = 4;
    localparam int NH = 3;
    localparam int NC = 2;
    localparam int WB = 12;
    localparam int CB = 4;
    localparam int ITER_CYC = NH*(NV+2) + NC*(NH+2) + 1;

    typedef logic [23:0] rec_t;
    localparam rec_t DC_CLS   = 24'h000001;
    localparam rec_t DC_HID   = 24'h000006;
    localparam rec_t DC_VIS   = 24'h000018;
    localparam rec_t DC_VAL   = 24'h01FFE0;
    localparam rec_t DC_PIX   = 24'h040000;
    localparam rec_t DC_FIRST = 24'h080000;

    logic            clk = 1'b0;
    logic            i_reset, i_start;
    logic [CB-1:0]   i_iter_num;
    logic            o_busy, o_done;
    logic [1:0]      o_vis_addr, o_hid_addr;
    logic            o_cls_addr;
    logic            i_vis_bit, i_sw_bit;
    logic [WB-1:0]   i_h_value, i_c_value;
    logic            o_en_h, o_en_c, o_first, o_pixel, o_switch;
    logic [WB-1:0]   o_value;
    logic            i_core_hidden, i_core_spike;
    logic [NC*CB-1:0] o_spike_count;
    logic            o_class_out;

    logic [3:0] img  = 4'b0110;
    logic [3:0] hpat = 4'b0101;
    logic       spike_mode = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    rec_t exp_q[$];
    rec_t dc_q[$];

    always #5 clk = ~clk;

    function automatic logic [11:0] hval(input int h, input int v);
        return 12'(12'h100 + h*16 + v);
    endfunction

    function automatic logic [11:0] cval(input int h, input int c);
        return 12'(12'h200 + h*4 + c);
    endfunction

    assign i_vis_bit     = img[o_vis_addr];
    assign i_h_value     = hval(int'(o_hid_addr), int'(o_vis_addr));
    assign i_c_value     = cval(int'(o_hid_addr), int'(o_cls_addr));
    assign i_sw_bit      = o_hid_addr[0];
    assign i_core_hidden = hpat[o_hid_addr];
    assign i_core_spike  = spike_mode ? (o_cls_addr == 1'b1) : 1'b1;

    rbm_sequencer #(
        .N_VIS(NV), .N_HID(NH), .N_CLS(NC), .W_BITS(WB), .CNT_BITS(CB)
    ) dut (
        .i_clock          (clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .i_iter_num       (i_iter_num),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_vis_addr       (o_vis_addr),
        .i_vis_bit        (i_vis_bit),
        .o_hid_addr       (o_hid_addr),
        .o_cls_addr       (o_cls_addr),
        .i_h_value        (i_h_value),
        .i_c_value        (i_c_value),
        .i_sw_bit         (i_sw_bit),
        .o_core_en_hidden (o_en_h),
        .o_core_en_classi (o_en_c),
        .o_core_first     (o_first),
        .o_core_pixel     (o_pixel),
        .o_core_value     (o_value),
        .o_core_switch    (o_switch),
        .i_core_hidden    (i_core_hidden),
        .i_core_spike     (i_core_spike),
        .o_spike_count    (o_spike_count),
        .o_class_out      (o_class_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic b, input logic dn,
                                input logic eh, input logic ec,
                                input logic fi, input logic px,
                                input logic sw, input logic [11:0] v,
                                input int vis, input int hid,
                                input int cls);
        return {b, dn, eh, ec, fi, px, sw, v, 2'(vis), 2'(hid), 1'(cls)};
    endfunction

    task automatic push(input rec_t r, input rec_t dc);
        exp_q.push_back(r);
        dc_q.push_back(dc);
    endtask

    task automatic build(input int iters);
        for (int it = 0; it < iters; it++) begin
            for (int n = 0; n < NH; n++) begin
                for (int k = 0; k < NV; k++)
                    push(mk(1, 0, 1, 0, k == 0, img[k], 1'(n),
                            hval(n, k), k, n, 0), DC_CLS);
                push(mk(1, 0, 1, 0, 0, 1, 1'(n), 0, 0, n, 0),
                     DC_VAL | DC_VIS | DC_CLS);
                push(mk(1, 0, 1, 0, 0, 0, 1'(n), 0, 0, n, 0),
                     DC_PIX | DC_VAL | DC_VIS | DC_CLS);
            end
            for (int c = 0; c < NC; c++) begin
                for (int k = 0; k <= NH; k++)
                    push(mk(1, 0, 0, 1, k == 0,
                            (k == NH) ? 1'b1 : hpat[k], 0,
                            cval(k, c), 0, k, c), DC_VIS);
                push(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, c),
                     DC_PIX | DC_VAL | DC_VIS | DC_HID);
            end
            push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                 DC_FIRST | DC_PIX | DC_VAL | DC_VIS | DC_HID | DC_CLS);
        end
        push(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             DC_FIRST | DC_PIX | DC_VAL | DC_VIS | DC_HID | DC_CLS);
    endtask

    task automatic run(input int iters, input int poke_at,
                       input int abort_at, input logic [7:0] exp_cnt,
                       input logic exp_cls);
        int   cyc;
        int   nbusy;
        bit   aborted;
        rec_t e, d, o;
        build(iters);
        i_iter_num = CB'(iters);
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc     = 0;
        nbusy   = 0;
        aborted = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            e = exp_q.pop_front();
            d = dc_q.pop_front();
            o = {o_busy, o_done, o_en_h, o_en_c, o_first, o_pixel,
                 o_switch, o_value, o_vis_addr, o_hid_addr, o_cls_addr};
            chk($sformatf("stream[%0d]", cyc), o & ~d, e & ~d);
            if (o_busy) nbusy++;
            if (e[22]) begin
                chk("spike_count", o_spike_count, exp_cnt);
                chk("class_out", o_class_out, exp_cls);
            end
            if (cyc == poke_at) begin
                i_start    = 1'b1;
                i_iter_num = 4'd5;
            end else begin
                i_start = 1'b0;
            end
            if (cyc == abort_at) begin
                i_reset = 1'b1;
                @(negedge clk);
                i_reset = 1'b0;
                aborted = 1;
                exp_q.delete();
                dc_q.delete();
                break;
            end
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
        if (aborted) begin
            chk("abort_busy", o_busy, 0);
            chk("abort_done", o_done, 0);
            chk("abort_en", {o_en_h, o_en_c}, 0);
            chk("abort_hid", o_hid_addr, 0);
            chk("abort_cnt", o_spike_count, 0);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("abort_nodone", {o_busy, o_done}, 0);
            end
        end else begin
            chk("timeout", exp_q.size(), 0);
            chk("busy_cycles", nbusy, iters * ITER_CYC);
            chk("idle_after", {o_busy, o_done}, 0);
            chk("count_hold", o_spike_count, exp_cnt);
            @(negedge clk);
            chk("still_idle", {o_busy, o_done}, 0);
        end
    endtask

    initial begin
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_iter_num = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy_done", {o_busy, o_done}, 0);
        chk("rst_core", {o_en_h, o_en_c, o_first, o_pixel, o_switch,
                         o_value}, 0);
        chk("rst_addr", {o_vis_addr, o_hid_addr, o_cls_addr}, 0);
        chk("rst_cnt", o_spike_count, 0);
        chk("rst_class", o_class_out, 0);
        i_reset = 1'b0;
        @(negedge clk);

        spike_mode = 1'b0;
        run(3, -1, -1, {4'd3, 4'd3}, 1'b0);

        spike_mode = 1'b1;
        run(15, -1, -1, {4'd15, 4'd0}, 1'b1);

        run(0, -1, -1, 8'h00, 1'b0);

        spike_mode = 1'b0;
        run(2, -1, 10, 8'h00, 1'b0);
        run(1, -1, -1, {4'd1, 4'd1}, 1'b0);

        spike_mode = 1'b1;
        run(2, 10, -1, {4'd2, 4'd0}, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
